// File: rtl/la_capture_sched.sv
// Run-mode scheduler: arms sample_ctrl, forces AUTO timeouts, swaps ping-pong banks at frame start (LA_CAPTURE_STATS_EN adds counters).
// Latency: start -> trigger_en next cycle; finished/frame_vs edges are registered and act one cycle after the input edge.
// Backpressure: none; stop aborts any state on the next cycle, start is ignored while busy.
module la_capture_sched #(
    parameter int               TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_VAL = TMO_W'(5000000),
    parameter int               HOLD_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        run_mode,
    input  logic              start,
    input  logic              stop,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              finished,
    input  logic              frame_vs,
    output logic              trigger_en,
    output logic              force_trig,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              busy,
    output logic              done
`ifdef LA_CAPTURE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       force_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_CAP,
        S_SWAP_WT,
        S_HOLD
    } state_t;

    localparam logic [1:0]       MODE_SINGLE = 2'd0;
    localparam logic [1:0]       MODE_AUTO   = 2'd2;
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_VAL - 1'b1;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          mode_r;
    logic                finished_d;
    logic                vs_d;
    logic                fin_rise;
    logic                vs_rise;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                is_auto;
    logic                is_single;
    logic                swap_go;
    logic                force_go;

    assign is_auto   = (mode_r == MODE_AUTO);
    assign is_single = (mode_r == MODE_SINGLE);
    assign swap_go   = (state == S_SWAP_WT) && vs_rise && !stop;
    // A finish edge in the timeout cycle wins over the forced trigger.
    assign force_go  = (state == S_WAIT_CAP) && is_auto && (tmo_cnt == TMO_LAST)
                       && !fin_rise && !stop;
    assign rd_bank   = ~wr_bank;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start) state_nxt = S_ARM;
                S_ARM:      state_nxt = S_WAIT_CAP;
                S_WAIT_CAP: if (fin_rise) state_nxt = S_SWAP_WT;
                S_SWAP_WT:  if (vs_rise) state_nxt = is_single ? S_IDLE : S_HOLD;
                S_HOLD:     if (hold_cnt >= holdoff) state_nxt = S_ARM;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        trigger_en = 1'b0;
        force_trig = 1'b0;
        busy       = 1'b0;
        trigger_en = (state == S_ARM) && !stop;
        force_trig = force_go;
        busy       = (state != S_IDLE);
    end

    // Edges are registered, so a level already high on WAIT_CAP entry never looks like a new edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            finished_d <= 1'b0;
            vs_d       <= 1'b0;
            fin_rise   <= 1'b0;
            vs_rise    <= 1'b0;
        end else begin
            finished_d <= finished;
            vs_d       <= frame_vs;
            fin_rise   <= finished & ~finished_d;
            vs_rise    <= frame_vs & ~vs_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_r   <= MODE_SINGLE;
            done     <= 1'b0;
            wr_bank  <= 1'b0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if ((state == S_IDLE) && start && !stop) begin
                mode_r <= run_mode;
                done   <= 1'b0;
            end
            // Counting past TMO_LAST to TMO_VAL and parking there gives a single force pulse.
            if (state == S_ARM) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT_CAP) && is_auto && (tmo_cnt != TMO_VAL)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (swap_go) begin
                wr_bank <= ~wr_bank;
                if (is_single) begin
                    done <= 1'b1;
                end
            end
            if (swap_go) begin
                hold_cnt <= '0;
            end else if ((state == S_HOLD) && (hold_cnt != '1)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

`ifdef LA_CAPTURE_STATS_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt <= '0;
            force_cnt <= '0;
        end else begin
            if (swap_go) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (force_go) begin
                force_cnt <= force_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_la_capture_sched.sv
// Directed bench for la_capture_sched with TMO_VAL=8; a generator mode emulates sample_ctrl and vsync for the free-running NORMAL run.
module tb_la_capture_sched;

    logic        sys_clk;
    logic        sys_rst;
    logic [1:0]  run_mode;
    logic        start;
    logic        stop;
    logic [15:0] holdoff;
    logic        finished;
    logic        frame_vs;
    logic        trigger_en;
    logic        force_trig;
    logic        wr_bank;
    logic        rd_bank;
    logic        busy;
    logic        done;
`ifdef LA_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] force_cnt;
`endif

    logic        fin_man, vs_man, fin_gen, vs_gen, gen_en;
    int          fin_ctr, vs_ctr;
    int          n_checks, n_errors;
    int          trig_seen, force_seen, swap_seen, busy_low;
    int          t0_trig, t0_force, t0_swap;
    logic        t1_active;
    logic        wr_prev, vs_h1, vs_h2, rst_h1;

    assign finished = gen_en ? fin_gen : fin_man;
    assign frame_vs = gen_en ? vs_gen  : vs_man;

    la_capture_sched #(
        .TMO_W  (24),
        .TMO_VAL(24'd8),
        .HOLD_W (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .run_mode  (run_mode),
        .start     (start),
        .stop      (stop),
        .holdoff   (holdoff),
        .finished  (finished),
        .frame_vs  (frame_vs),
        .trigger_en(trigger_en),
        .force_trig(force_trig),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .busy      (busy),
        .done      (done)
`ifdef LA_CAPTURE_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .force_cnt (force_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_trig"},  32'(trigger_en), 32'd0);
        check({tag, "_force"}, 32'(force_trig), 32'd0);
        check({tag, "_wr"},    32'(wr_bank),    32'd0);
        check({tag, "_rd"},    32'(rd_bank),    32'd1);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
`ifdef LA_CAPTURE_STATS_EN
        check({tag, "_fcnt"},  32'(frame_cnt),  32'd0);
        check({tag, "_tcnt"},  32'(force_cnt),  32'd0);
`endif
    endtask

    // Emulated sample_ctrl (finished 20 cycles after arm, cleared by arm) and a 100-cycle vsync.
    always @(posedge sys_clk) begin
        #1;
        if (!gen_en) begin
            fin_ctr = 0;
            vs_ctr  = 0;
            fin_gen = 1'b0;
            vs_gen  = 1'b0;
        end else begin
            if (trigger_en) begin
                fin_ctr = 0;
                fin_gen = 1'b0;
            end else begin
                if (fin_ctr < 20) fin_ctr++;
                if (fin_ctr == 20) fin_gen = 1'b1;
            end
            vs_ctr++;
            vs_gen = ((vs_ctr % 100) == 0);
        end
    end

    // Per-cycle observers: bank invariant, swaps must follow a vsync by two cycles, pulse counts.
    always @(negedge sys_clk) begin
        check("bank_inv", 32'(rd_bank), 32'(!wr_bank));
        if (!rst_h1 && (wr_bank !== wr_prev)) begin
            swap_seen++;
            check("swap_after_vs", 32'(vs_h2), 32'd1);
        end
        if (trigger_en) trig_seen++;
        if (force_trig) force_seen++;
        if (t1_active && !busy) busy_low++;
        vs_h2   = vs_h1;
        vs_h1   = frame_vs;
        wr_prev = wr_bank;
        rst_h1  = sys_rst;
    end

    initial begin
        n_checks = 0; n_errors = 0;
        trig_seen = 0; force_seen = 0; swap_seen = 0; busy_low = 0;
        t1_active = 1'b0; wr_prev = 1'b0; vs_h1 = 1'b0; vs_h2 = 1'b0; rst_h1 = 1'b1;
        fin_man = 1'b0; vs_man = 1'b0; gen_en = 1'b0;
        sys_rst = 1'b1; run_mode = 2'd0; start = 1'b0; stop = 1'b0; holdoff = 16'd0;
        step(3);
        sys_rst = 1'b0;
        check_reset_vals("rst");
        step(2);

        // SINGLE: one arm, one swap, done; second start clears done, stop inside ARM drops the pulse.
        t0_trig = trig_seen;
        run_mode = 2'd0; start = 1'b1;
        step(1); start = 1'b0;
        check("t2_arm", 32'(trigger_en), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        step(1);
        check("t2_arm_once", 32'(trigger_en), 32'd0);
        fin_man = 1'b1;
        step(2);
        vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        check("t2_pre_swap_wr", 32'(wr_bank), 32'd0);
        step(1);
        check("t2_swap_wr", 32'(wr_bank), 32'd1);
        check("t2_swap_rd", 32'(rd_bank), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        step(2);
        check("t2_trig_count", 32'(trig_seen - t0_trig), 32'd1);
        start = 1'b1;
        step(1); start = 1'b0;
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_rearm", 32'(trigger_en), 32'd1);
        stop = 1'b1; #1;
        check("t4_stop_in_arm", 32'(trigger_en), 32'd0);
        step(1); stop = 1'b0;
        check("t4_stop_arm_idle", 32'(busy), 32'd0);

        // AUTO: force at arm+8 exactly once, later finish swaps, holdoff=0, stale finished level ignored.
        fin_man = 1'b0; run_mode = 2'd2; holdoff = 16'd0;
        step(2);
        t0_force = force_seen;
        start = 1'b1;
        step(1); start = 1'b0;
        check("t3_arm", 32'(trigger_en), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(1);
            check("t3_no_force_early", 32'(force_trig), 32'd0);
        end
        step(1);
        check("t3_force_at_8", 32'(force_trig), 32'd1);
        step(1);
        check("t3_force_1cyc", 32'(force_trig), 32'd0);
        check("t3_still_busy", 32'(busy), 32'd1);
        step(4);
        check("t3_force_once", 32'(force_seen - t0_force), 32'd1);
        fin_man = 1'b1;
        step(2);
        vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        check("t3_pre_swap_wr", 32'(wr_bank), 32'd1);
        step(1);
        check("t3_swap_wr", 32'(wr_bank), 32'd0);
        check("t3_swap_rd", 32'(rd_bank), 32'd1);
        step(1);
        check("t3_holdoff0_arm", 32'(trigger_en), 32'd1);
        step(7);
        check("t3_stale_fin_no_force_yet", 32'(force_trig), 32'd0);
        step(1);
        check("t3_stale_fin_ignored", 32'(force_trig), 32'd1);
        stop = 1'b1;
        step(1); stop = 1'b0;
        check("t3_stop_idle", 32'(busy), 32'd0);

        // AUTO: finish edge lands on the timeout cycle and on a vsync edge.
        fin_man = 1'b0;
        step(2);
        t0_force = force_seen;
        start = 1'b1;
        step(1); start = 1'b0;
        step(7);
        fin_man = 1'b1; vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        check("t5_fin_beats_tmo", 32'(force_trig), 32'd0);
        step(3);
        check("t5_vs_with_fin_unused", 32'(wr_bank), 32'd0);
        check("t5_wait_busy", 32'(busy), 32'd1);
        vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        check("t5_pre_swap_wr", 32'(wr_bank), 32'd0);
        step(1);
        check("t5_swap_wr", 32'(wr_bank), 32'd1);
        check("t5_no_force", 32'(force_seen - t0_force), 32'd0);
        stop = 1'b1;
        step(1); stop = 1'b0;
        check("t5_stop_idle", 32'(busy), 32'd0);
`ifdef LA_CAPTURE_STATS_EN
        check("stats_frames_3", 32'(frame_cnt), 32'd3);
        check("stats_forces_2", 32'(force_cnt), 32'd2);
`endif

        // Stop in WAIT_CAP, stop in SWAP_WT coinciding with the vsync edge, start+stop together.
        run_mode = 2'd1; fin_man = 1'b0;
        step(2);
        start = 1'b1;
        step(1); start = 1'b0;
        step(1); stop = 1'b1;
        step(1); stop = 1'b0;
        check("t4_stop_wait_idle", 32'(busy), 32'd0);
        check("t4_stop_wait_wr", 32'(wr_bank), 32'd1);
        start = 1'b1;
        step(1); start = 1'b0;
        step(1); fin_man = 1'b1;
        step(1); vs_man = 1'b1;
        step(1); vs_man = 1'b0; stop = 1'b1;
        check("t4_in_swap_wt", 32'(busy), 32'd1);
        step(1); stop = 1'b0;
        check("t4_stop_swap_idle", 32'(busy), 32'd0);
        check("t4_stop_swap_wr", 32'(wr_bank), 32'd1);
        step(3);
        check("t4_no_late_swap", 32'(wr_bank), 32'd1);
        start = 1'b1; stop = 1'b1;
        step(1); start = 1'b0; stop = 1'b0;
        check("t4_start_stop_idle", 32'(busy), 32'd0);
        check("t4_start_stop_notrig", 32'(trigger_en), 32'd0);

        // NORMAL holdoff=4, two swaps, then reset while in HOLD.
        holdoff = 16'd4; fin_man = 1'b0;
        step(2);
        start = 1'b1;
        step(1); start = 1'b0;
        step(1); fin_man = 1'b1;
        step(2); vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        step(1);
        check("t6_swap1_wr", 32'(wr_bank), 32'd0);
        fin_man = 1'b0;
        step(4);
        check("t6_hold_no_arm", 32'(trigger_en), 32'd0);
        check("t6_hold_busy", 32'(busy), 32'd1);
        step(1);
        check("t6_holdoff4_arm", 32'(trigger_en), 32'd1);
        step(1); fin_man = 1'b1;
        step(2); vs_man = 1'b1;
        step(1); vs_man = 1'b0;
        step(1);
        check("t6_swap2_wr", 32'(wr_bank), 32'd1);
`ifdef LA_CAPTURE_STATS_EN
        check("t6_frames_5", 32'(frame_cnt), 32'd5);
`endif
        step(1);
        check("t6_in_hold", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        step(1); sys_rst = 1'b0;
        check_reset_vals("t6_rst");

        // Free-running NORMAL against emulated sample_ctrl and a 100-cycle frame.
        fin_man = 1'b0; vs_man = 1'b0; run_mode = 2'd1; holdoff = 16'd4;
        step(2);
        t0_trig = trig_seen; t0_swap = swap_seen;
        gen_en = 1'b1; start = 1'b1;
        step(1); start = 1'b0;
        t1_active = 1'b1;
        step(519);
        t1_active = 1'b0;
        check("t1_trig_per_frame", 32'(trig_seen - t0_trig), 32'd6);
        check("t1_swaps", 32'(swap_seen - t0_swap), 32'd5);
        check("t1_busy_held", 32'(busy_low), 32'd0);
        check("t1_wr_after_5", 32'(wr_bank), 32'd1);
        stop = 1'b1;
        step(1); stop = 1'b0; gen_en = 1'b0;
        check("t1_stop_idle", 32'(busy), 32'd0);
        check("t1_stop_wr_kept", 32'(wr_bank), 32'd1);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
